// File: rtl/vga_timing_param.sv
// vga_timing_param
// Parametrised VGA timing generator. It produces the raster counters, the
// blanking and sync flags, and a start-of-frame pulse for any resolution and
// porch set chosen at elaboration. Sync polarity is programmable.
//
// All outputs are registered. On each ce=1 edge the next counter values are
// computed first, and every flag is decoded from those same next values. The
// flags therefore always match hcount/vcount in the same cycle.
//
// Ports:
//   clk        in   pixel-domain clock
//   rst        in   asynchronous active-high reset
//   ce         in   pixel advance enable (tie 1 for one pixel per clk)
//   hcount     out  [CNT_W]  horizontal position
//   vcount     out  [CNT_W]  vertical position
//   hsync      out  horizontal sync, active level = HSYNC_POL
//   vsync      out  vertical sync, active level = VSYNC_POL
//   hblnk      out  horizontal blanking (hcount >= H_ACTIVE)
//   vblnk      out  vertical blanking (vcount >= V_ACTIVE)
//   sof        out  one-cycle pulse after the wrap to (0,0)
//   frame_cnt  out  [FCNT_W] completed frames, present only when the
//                   macro VGA_TIMING_FRAME_CNT_EN is defined
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN

module vga_timing_param #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int CNT_W     = 11,
   parameter int FCNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   output logic [CNT_W-1:0]  hcount,
   output logic [CNT_W-1:0]  vcount,
   output logic              hsync,
   output logic              vsync,
   output logic              hblnk,
   output logic              vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic [FCNT_W-1:0] frame_cnt,
`endif
   output logic              sof
);

   localparam int    H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int    V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam longint MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   // Each porch is at least 1, so every boundary below fits in CNT_W bits.
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_BLANK  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_BLANK  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if ((longint'(1) << CNT_W) < MAX_TOTAL) begin : g_err_cnt_w
      $error("vga_timing_param: CNT_W too small for H_TOTAL/V_TOTAL");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
   begin : g_err_porch
      $error("vga_timing_param: porch and sync widths must be >= 1");
   end
   if (FCNT_W < 1) begin : g_err_fcnt_w
      $error("vga_timing_param: FCNT_W must be >= 1");
   end

   logic             h_wrap;
   logic             v_wrap;
   logic             frame_end;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;

   always_comb begin
      h_wrap    = (hcount == H_LAST);
      v_wrap    = (vcount == V_LAST);
      frame_end = h_wrap && v_wrap;
      h_next    = h_wrap ? '0 : hcount + CNT_W'(1);
      v_next    = vcount;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : vcount + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
         hblnk  <= 1'b0;
         vblnk  <= 1'b0;
         hsync  <= ~HSYNC_POL;
         vsync  <= ~VSYNC_POL;
         sof    <= 1'b0;
      end else if (ce) begin
         hcount <= h_next;
         vcount <= v_next;
         hblnk  <= (h_next >= H_BLANK);
         vblnk  <= (v_next >= V_BLANK);
         hsync  <= ((h_next >= HS_START) && (h_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
         vsync  <= ((v_next >= VS_START) && (v_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
         sof    <= frame_end;
      end else begin
         // Everything else holds while ce=0. The pulse must not stretch.
         sof <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (ce && frame_end) begin
         frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param using a reduced raster:
//   H: 8 active, 2 fp, 3 sync, 2 bp -> 15 per line (hsync at h=10..12)
//   V: 4 active, 1 fp, 2 sync, 1 bp -> 8 lines (vsync at v=5..6)
//   One frame takes 120 pixels.
// dut_a uses active-high syncs. dut_b uses active-low syncs.
module tb_vga_timing_param;

   localparam int CW = 5;
   localparam int FW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [CW-1:0] hcount_a, vcount_a, hcount_b, vcount_b;
   logic          hsync_a, vsync_a, hblnk_a, vblnk_a, sof_a;
   logic          hsync_b, vsync_b, hblnk_b, vblnk_b, sof_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FW-1:0] frame_cnt_a, frame_cnt_b;
`endif

   always #5 clk = ~clk;

   vga_timing_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW), .FCNT_W(FW)
   ) dut_a (
      .clk(clk), .rst(rst), .ce(ce),
      .hcount(hcount_a), .vcount(vcount_a),
      .hsync(hsync_a), .vsync(vsync_a),
      .hblnk(hblnk_a), .vblnk(vblnk_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(frame_cnt_a),
`endif
      .sof(sof_a)
   );

   vga_timing_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW), .FCNT_W(FW)
   ) dut_b (
      .clk(clk), .rst(rst), .ce(ce),
      .hcount(hcount_b), .vcount(vcount_b),
      .hsync(hsync_b), .vsync(vsync_b),
      .hblnk(hblnk_b), .vblnk(vblnk_b),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(frame_cnt_b),
`endif
      .sof(sof_b)
   );

   int total = 0;
   int bad   = 0;
   int kk    = 0;

   typedef struct {
      int k;        // ce=1 edges since reset release
      int h;
      int v;
      bit hb;
      bit vb;
      bit hs;       // sync active (logical, before polarity)
      bit vs;
      bit sof;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic c);
      ce = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      vecs[0]  = '{0,   0,  0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1,   1,  0, 0, 0, 0, 0, 0};
      vecs[2]  = '{7,   7,  0, 0, 0, 0, 0, 0};
      vecs[3]  = '{8,   8,  0, 1, 0, 0, 0, 0};
      vecs[4]  = '{10,  10, 0, 1, 0, 1, 0, 0};
      vecs[5]  = '{12,  12, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{13,  13, 0, 1, 0, 0, 0, 0};
      vecs[7]  = '{14,  14, 0, 1, 0, 0, 0, 0};
      vecs[8]  = '{15,  0,  1, 0, 0, 0, 0, 0};
      vecs[9]  = '{59,  14, 3, 1, 0, 0, 0, 0};
      vecs[10] = '{60,  0,  4, 0, 1, 0, 0, 0};
      vecs[11] = '{74,  14, 4, 1, 1, 0, 0, 0};
      vecs[12] = '{75,  0,  5, 0, 1, 0, 1, 0};
      vecs[13] = '{100, 10, 6, 1, 1, 1, 1, 0};
      vecs[14] = '{104, 14, 6, 1, 1, 0, 1, 0};
      vecs[15] = '{105, 0,  7, 0, 1, 0, 0, 0};
      vecs[16] = '{119, 14, 7, 1, 1, 0, 0, 0};
      vecs[17] = '{120, 0,  0, 0, 0, 0, 0, 1};
      vecs[18] = '{121, 1,  0, 0, 0, 0, 0, 0};
      vecs[19] = '{240, 0,  0, 0, 0, 0, 0, 1};

      rst = 1'b1;
      ce  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Free-running raster with ce=1, sampled at chosen positions.
      for (int i = 0; i < 20; i++) begin
         while (kk < vecs[i].k) begin
            tick(1'b1);
            kk++;
         end
         chk($sformatf("k%0d_hcount", vecs[i].k), hcount_a, vecs[i].h);
         chk($sformatf("k%0d_vcount", vecs[i].k), vcount_a, vecs[i].v);
         chk($sformatf("k%0d_hblnk", vecs[i].k), hblnk_a, vecs[i].hb);
         chk($sformatf("k%0d_vblnk", vecs[i].k), vblnk_a, vecs[i].vb);
         chk($sformatf("k%0d_hsync_hi", vecs[i].k), hsync_a, vecs[i].hs);
         chk($sformatf("k%0d_vsync_hi", vecs[i].k), vsync_a, vecs[i].vs);
         chk($sformatf("k%0d_hsync_lo", vecs[i].k), hsync_b, !vecs[i].hs);
         chk($sformatf("k%0d_vsync_lo", vecs[i].k), vsync_b, !vecs[i].vs);
         chk($sformatf("k%0d_sof", vecs[i].k), sof_a, vecs[i].sof);
         chk($sformatf("k%0d_sof_b", vecs[i].k), sof_b, vecs[i].sof);
      end

      // Asynchronous reset at (5,3). kk=240 is (0,0), so 50 more pixels.
      repeat (50) tick(1'b1);
      chk("pre_rst_hcount", hcount_a, 5);
      chk("pre_rst_vcount", vcount_a, 3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_hcount", hcount_a, 0);
      chk("async_rst_vcount", vcount_a, 0);
      chk("async_rst_hsync_hi", hsync_a, 0);
      chk("async_rst_hsync_lo", hsync_b, 1);
      chk("async_rst_vsync_lo", vsync_b, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick(1'b1);
      chk("post_rst_hcount", hcount_a, 1);
      chk("post_rst_vcount", vcount_a, 0);
      chk("post_rst_sof", sof_a, 0);
      n = 1;
      while (!sof_a && n < 200) begin
         tick(1'b1);
         n++;
      end
      chk("post_rst_frame_len", n, 120);

      // ce gating around the frame wrap. The current position is (0,0).
      repeat (119) tick(1'b1);
      chk("ce_pre_wrap_hcount", hcount_a, 14);
      tick(1'b1);
      chk("ce_wrap_sof", sof_a, 1);
      tick(1'b0);
      chk("ce0_sof_drop", sof_a, 0);
      chk("ce0_hold_hcount", hcount_a, 0);
      chk("ce0_hold_vcount", vcount_a, 0);
      tick(1'b1);
      chk("ce1_resume_hcount", hcount_a, 1);
      chk("ce1_resume_sof", sof_a, 0);

      // Alternating ce for 30 clks advances exactly one line: (1,0) -> (1,1).
      for (int i = 0; i < 30; i++) begin
         tick(i[0]);
         if (i == 10) begin
            chk("alt_ce_mid_hcount", hcount_a, 6);
            chk("alt_ce_mid_hblnk", hblnk_a, 0);
         end
      end
      chk("alt_ce_line_hcount", hcount_a, 1);
      chk("alt_ce_line_vcount", vcount_a, 1);

`ifdef VGA_TIMING_FRAME_CNT_EN
      #2 rst = 1'b1;
      #1;
      chk("fcnt_rst", frame_cnt_a, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int f = 1; f <= 4; f++) begin
         n = 0;
         do begin
            tick(1'b1);
            n++;
         end while (!sof_a && n < 200);
         chk($sformatf("fcnt_frame%0d_len", f), n, 120);
         chk($sformatf("fcnt_frame%0d", f), frame_cnt_a, f % 4);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
